// File: rtl/calc_pkg.sv
// Shared encodings, FSM states and constant helpers for the parametrised decimal calculator.
// CALC_DIV_EN (optional): adds '/' (cmd 13) to the operator set.
package calc_pkg;

  localparam logic [3:0] CMD_ADD = 4'd10;
  localparam logic [3:0] CMD_SUB = 4'd11;
  localparam logic [3:0] CMD_MUL = 4'd12;
  localparam logic [3:0] CMD_DIV = 4'd13;
  localparam logic [3:0] CMD_EQ  = 4'd14;
  localparam logic [3:0] CMD_BS  = 4'd15;

  localparam logic [1:0] ST_ERROR = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_READY = 2'b10;
  localparam logic [1:0] ST_PRINT = 2'b11;

  localparam logic [3:0] BLANK = 4'hF;

  typedef enum logic [2:0] {WAIT_A, WAIT_B, CALC, SHOW, ERROR} state_t;

  function automatic int unsigned pow10(input int n);
    int unsigned v;
    v = 1;
    for (int i = 0; i < n; i++) v = v * 10;
    return v;
  endfunction

  function automatic logic is_op(input logic [3:0] c);
`ifdef CALC_DIV_EN
    return c inside {CMD_ADD, CMD_SUB, CMD_MUL, CMD_DIV};
`else
    return c inside {CMD_ADD, CMD_SUB, CMD_MUL};
`endif
  endfunction

endpackage

// File: rtl/calc_muldiv.sv
// Iterative shift-add multiplier (and restoring divider under CALC_DIV_EN); start -> done in VAL_W+1 cycles.
// No backpressure: start is only issued while idle, done is a one-cycle pulse.
module calc_muldiv
  import calc_pkg::*;
#(
  parameter int          VAL_W = 27,
  parameter int unsigned LIMIT = 100000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
`ifdef CALC_DIV_EN
  input  logic             div,
`endif
  input  logic [VAL_W-1:0] a,
  input  logic [VAL_W-1:0] b,
  output logic [VAL_W-1:0] result,
  output logic             ovf,
  output logic             done
);

  localparam int CW = $clog2(VAL_W + 1);

  logic                 busy;
  logic [CW-1:0]        cnt;
  logic [2*VAL_W-1:0]   acc, mcand;
  logic [VAL_W-1:0]     mplier;  // multiplier, or dividend shifting into quotient

`ifdef CALC_DIV_EN
  logic                 div_r;
  logic [VAL_W-1:0]     rem, dvsr;
  logic [VAL_W:0]       rem_sh;
  assign rem_sh = {rem, mplier[VAL_W-1]};
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      done   <= 1'b0;
`ifdef CALC_DIV_EN
      div_r  <= 1'b0;
      rem    <= '0;
      dvsr   <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (start) begin
        busy  <= 1'b1;
        cnt   <= '0;
        acc   <= '0;
        mcand <= {{VAL_W{1'b0}}, a};
`ifdef CALC_DIV_EN
        div_r  <= div;
        rem    <= '0;
        dvsr   <= b;
        mplier <= div ? a : b;
`else
        mplier <= b;
`endif
      end else if (busy) begin
`ifdef CALC_DIV_EN
        if (div_r) begin
          if (rem_sh >= {1'b0, dvsr}) begin
            rem    <= VAL_W'(rem_sh - {1'b0, dvsr});
            mplier <= {mplier[VAL_W-2:0], 1'b1};
          end else begin
            rem    <= rem_sh[VAL_W-1:0];
            mplier <= {mplier[VAL_W-2:0], 1'b0};
          end
        end else
`endif
        begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
        end
        cnt <= cnt + CW'(1);
        if (cnt == CW'(VAL_W - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

`ifdef CALC_DIV_EN
  assign result = div_r ? mplier : acc[VAL_W-1:0];
  assign ovf    = !div_r && ((acc[2*VAL_W-1:VAL_W] != '0) || (acc[VAL_W-1:0] >= VAL_W'(LIMIT)));
`else
  assign result = acc[VAL_W-1:0];
  assign ovf    = (acc[2*VAL_W-1:VAL_W] != '0) || (acc[VAL_W-1:0] >= VAL_W'(LIMIT));
`endif

endmodule

// File: rtl/calc_param.sv
// DIGITS-digit decimal calculator: keypad commands in, one display digit per cycle out (SHOW lasts DIGITS cycles).
// cmd_ready drops while BUSY/PRINTING (commands are dropped, not queued); CALC_DIV_EN enables '/'.
module calc_param
  import calc_pkg::*;
#(
  parameter  int DIGITS = 8,
  localparam int VAL_W  = $clog2(pow10(DIGITS)),
  localparam int POS_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [3:0]       cmd,
  output logic             cmd_ready,
  output logic [1:0]       status,
  output logic [3:0]       data,
  output logic [POS_W-1:0] pos,
  output logic             data_valid
);

  localparam int unsigned      LIMIT    = pow10(DIGITS);
  localparam logic [VAL_W-1:0] LIM_V    = VAL_W'(LIMIT);
  localparam logic [VAL_W-1:0] GROW_V   = VAL_W'(pow10(DIGITS - 1));
  localparam logic [VAL_W-1:0] TEN      = VAL_W'(10);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(DIGITS - 1);

  state_t             state, state_nx, ret_state, ret_nx;
  logic [VAL_W-1:0]   a, a_nx, b, b_nx, shadow, shadow_nx, cur, nv, show_val;
  logic [3:0]         op, op_nx;
  logic [POS_W-1:0]   cnt, cnt_nx;
  logic [VAL_W:0]     sum;
  logic               accept, show_req, md_start, md_done, md_ovf;
  logic [VAL_W-1:0]   md_result;

  calc_muldiv #(.VAL_W(VAL_W), .LIMIT(LIMIT)) u_muldiv (
    .clock  (clock),
    .reset  (reset),
    .start  (md_start),
`ifdef CALC_DIV_EN
    .div    (op == CMD_DIV),
`endif
    .a      (a),
    .b      (b),
    .result (md_result),
    .ovf    (md_ovf),
    .done   (md_done)
  );

  always_comb begin
    status = ST_READY;
    case (state)
      CALC:    status = ST_BUSY;
      SHOW:    status = ST_PRINT;
      ERROR:   status = ST_ERROR;
      default: status = ST_READY;
    endcase
  end

  // ERROR only listens for backspace; everything else is refused at the handshake.
  assign cmd_ready = (state == ERROR) ? (cmd == CMD_BS) : (state == WAIT_A || state == WAIT_B);
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_nx  = state;
    ret_nx    = ret_state;
    a_nx      = a;
    b_nx      = b;
    op_nx     = op;
    shadow_nx = shadow;
    cnt_nx    = cnt;
    md_start  = 1'b0;
    show_req  = 1'b0;
    show_val  = shadow;
    cur       = (state == WAIT_B) ? b : a;
    nv        = cur;
    sum       = {1'b0, a} + {1'b0, b};
    case (state)
      WAIT_A, WAIT_B: if (accept) begin
        if (cmd <= 4'd9) begin
          if (cur < GROW_V) begin
            nv       = cur * TEN + VAL_W'(cmd);
            show_req = 1'b1;
          end
        end else if (cmd == CMD_BS) begin
          nv       = cur / TEN;
          show_req = 1'b1;
        end else if (is_op(cmd)) begin
          if (state == WAIT_A) begin
            op_nx    = cmd;
            b_nx     = '0;
            state_nx = WAIT_B;
          end else begin
            state_nx = ERROR;
          end
        end else if (cmd == CMD_EQ && state == WAIT_B) begin
          state_nx = CALC;
          md_start = (op == CMD_MUL);
`ifdef CALC_DIV_EN
          if (op == CMD_DIV && b != '0) md_start = 1'b1;
`endif
        end
        if (show_req) begin
          if (state == WAIT_A) a_nx = nv;
          else                 b_nx = nv;
          show_val = nv;
          ret_nx   = state;
        end
      end
      CALC: begin
        ret_nx = WAIT_A;
        case (op)
          CMD_ADD: begin
            if (sum >= {1'b0, LIM_V}) state_nx = ERROR;
            else begin
              a_nx     = sum[VAL_W-1:0];
              show_req = 1'b1;
            end
          end
          CMD_SUB: begin
            if (a < b) state_nx = ERROR;
            else begin
              a_nx     = a - b;
              show_req = 1'b1;
            end
          end
          default: begin
`ifdef CALC_DIV_EN
            if (op == CMD_DIV && b == '0) state_nx = ERROR;
            else
`endif
            if (md_done) begin
              if (md_ovf) state_nx = ERROR;
              else begin
                a_nx     = md_result;
                show_req = 1'b1;
              end
            end
          end
        endcase
        show_val = a_nx;
      end
      SHOW: begin
        shadow_nx = shadow / TEN;
        cnt_nx    = cnt + POS_W'(1);
        if (cnt == LAST_POS) state_nx = ret_state;
      end
      ERROR: if (accept) begin
        a_nx     = '0;
        b_nx     = '0;
        op_nx    = '0;
        state_nx = WAIT_A;
      end
      default: state_nx = WAIT_A;
    endcase
    if (show_req) begin
      shadow_nx = show_val;
      cnt_nx    = '0;
      state_nx  = SHOW;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= WAIT_A;
      ret_state  <= WAIT_A;
      a          <= '0;
      b          <= '0;
      op         <= '0;
      shadow     <= '0;
      cnt        <= '0;
      data       <= '0;
      pos        <= '0;
      data_valid <= 1'b0;
    end else begin
      state      <= state_nx;
      ret_state  <= ret_nx;
      a          <= a_nx;
      b          <= b_nx;
      op         <= op_nx;
      shadow     <= shadow_nx;
      cnt        <= cnt_nx;
      data_valid <= (state == SHOW);
      // Leading zeros blank out, but position 0 always shows a digit so zero reads as '0'.
      if (state == SHOW) begin
        pos  <= cnt;
        data <= (cnt != '0 && shadow == '0) ? BLANK : 4'(shadow % TEN);
      end
    end
  end

endmodule
